// File: rtl/mine_pkg.sv
// Shared definitions for the mine placer: board geometry, cell address type,
// LFSR tap mask and step function, and the placement FSM states.
package mine_pkg;

    localparam int BOARD_W     = 5;
    localparam int BOARD_CELLS = BOARD_W * BOARD_W;

    typedef logic [4:0] cell_addr_t;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1 (stages 8,6,5,4 -> bits 7,5,4,3).
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit maximal-length LFSR; reloads SEED on restart and
// exposes its full state.
module lfsr8
    import mine_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clka,
    input  logic       restart,
    output logic [7:0] lfsr
);

    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clka) begin
        if (restart) lfsr <= SEED;
        else         lfsr <= lfsr_step(lfsr);
    end

endmodule

// File: rtl/mine_placer.sv
// Mine placement responder: on start, clears the 5x5 map and places NUM_MINES
// distinct mines from LFSR candidates; serves a registered single-cell read.
// Optional macro MINE_SAFE_FIRST_EN keeps cell safe_addr mine-free.
module mine_placer
    import mine_pkg::*;
#(
    parameter int         NUM_MINES = 5,
    parameter logic [7:0] SEED      = 8'hA5
) (
    input  logic                   clka,
    input  logic                   restart,
    input  logic                   start,
    input  cell_addr_t             safe_addr,
    input  cell_addr_t             cell_addr,
    output logic                   place_done,
    output logic                   busy,
    output logic [BOARD_CELLS-1:0] mine_map,
    output cell_addr_t             mine_count,
    output logic                   cell_mine
);

    localparam cell_addr_t TARGET = cell_addr_t'(NUM_MINES);

    logic [7:0]  lfsr;
    state_e      state;
    cell_addr_t  candidate;
    cell_addr_t  count_inc;
    logic [31:0] map_ext;
    logic [BOARD_CELLS-1:0] cand_bit;
    logic        is_safe;
    logic        accept;

    lfsr8 #(.SEED(SEED)) u_lfsr (
        .clka    (clka),
        .restart (restart),
        .lfsr    (lfsr)
    );

    assign candidate = lfsr[4:0];
    assign count_inc = mine_count + 5'd1;
    // Zero-padding to 32 entries makes addresses 25..31 read back as empty.
    assign map_ext   = {7'd0, mine_map};
    assign cand_bit  = BOARD_CELLS'(1) << candidate;

`ifdef MINE_SAFE_FIRST_EN
    logic [2:0] unused_lfsr;
    assign unused_lfsr = lfsr[7:5];
    assign is_safe     = (candidate == safe_addr);
`else
    logic [7:0] unused_bits;
    assign unused_bits = {lfsr[7:5], safe_addr};
    assign is_safe     = 1'b0;
`endif

    assign accept = (candidate < cell_addr_t'(BOARD_CELLS)) && !map_ext[candidate] && !is_safe;

    // NOTE: the mine map is a plain register bank, so it is cleared by the
    // synchronous restart like the rest of the state; no stale map survives.
    always_ff @(posedge clka) begin
        if (restart) begin
            state      <= ST_IDLE;
            mine_map   <= '0;
            mine_count <= '0;
            place_done <= 1'b0;
            busy       <= 1'b0;
            cell_mine  <= 1'b0;
        end else begin
            cell_mine <= map_ext[cell_addr];
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_GEN;
                        mine_map   <= '0;
                        mine_count <= '0;
                        place_done <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                ST_GEN: begin
                    if (accept) begin
                        mine_map   <= mine_map | cand_bit;
                        mine_count <= count_inc;
                        if (count_inc == TARGET) begin
                            state      <= ST_DONE;
                            busy       <= 1'b0;
                            place_done <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mine_placer.sv
// Randomized self-checking bench for mine_placer: three instances
// (5, 24 and 1 mines) checked against a behavioural placement model.
module tb_mine_placer;

    localparam logic [7:0] SEED = 8'hA5;
    localparam int NM0 = 5;
    localparam int NM1 = 24;
    localparam int NM2 = 1;

    logic              clka = 1'b0;
    logic              restart = 1'b1;
    logic [2:0]        start = '0;
    logic [4:0]        safe_addr = 5'd12;
    logic [4:0]        cell_addr = '0;
    logic [2:0]        place_done;
    logic [2:0]        busy;
    logic [2:0]        cell_mine;
    logic [2:0][24:0]  mine_map;
    logic [2:0][4:0]   mine_count;
    logic [7:0]        ref_lfsr;

    int tests = 0;
    int fails = 0;

    always #5 clka = ~clka;

    mine_placer #(.NUM_MINES(NM0), .SEED(SEED)) dut5 (
        .clka(clka), .restart(restart), .start(start[0]), .safe_addr(safe_addr),
        .cell_addr(cell_addr), .place_done(place_done[0]), .busy(busy[0]),
        .mine_map(mine_map[0]), .mine_count(mine_count[0]), .cell_mine(cell_mine[0]));

    mine_placer #(.NUM_MINES(NM1), .SEED(SEED)) dut24 (
        .clka(clka), .restart(restart), .start(start[1]), .safe_addr(safe_addr),
        .cell_addr(cell_addr), .place_done(place_done[1]), .busy(busy[1]),
        .mine_map(mine_map[1]), .mine_count(mine_count[1]), .cell_mine(cell_mine[1]));

    mine_placer #(.NUM_MINES(NM2), .SEED(SEED)) dut1 (
        .clka(clka), .restart(restart), .start(start[2]), .safe_addr(safe_addr),
        .cell_addr(cell_addr), .place_done(place_done[2]), .busy(busy[2]),
        .mine_map(mine_map[2]), .mine_count(mine_count[2]), .cell_mine(cell_mine[2]));

    // Polynomial x^8+x^6+x^5+x^4+1: feedback from stages 8,6,5,4, shifted in at the bottom.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        logic fb;
        fb = v[7] ^ v[5] ^ v[4] ^ v[3];
        return {v[6:0], fb};
    endfunction

    // Reference LFSR running in lockstep with every instance's generator.
    always @(posedge clka) ref_lfsr <= restart ? SEED : lfsr_next(ref_lfsr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nm_of(input int w);
        case (w)
            0:       return NM0;
            1:       return NM1;
            default: return NM2;
        endcase
    endfunction

    // Placement from the rules: walk successive LFSR states after the start
    // edge, keeping each in-range, unused (and non-safe) low-5-bit value.
    function automatic void model_place(input logic [7:0] l0, input int n,
                                        output logic [24:0] map, output int edges);
        logic [7:0] v;
        int placed;
        int c;
        bit blocked;
        v = l0;
        map = '0;
        edges = 0;
        placed = 0;
        while (placed < n && edges < 20000) begin
            v = lfsr_next(v);
            edges++;
            c = int'(v[4:0]);
            blocked = (c >= 25);
            if (!blocked) blocked = map[c];
`ifdef MINE_SAFE_FIRST_EN
            if (c == int'(safe_addr)) blocked = 1'b1;
`endif
            if (!blocked) begin
                map[c] = 1'b1;
                placed++;
            end
        end
    endfunction

    task automatic run_game(input int w, input bit dbl, output logic [24:0] got_map);
        logic [24:0] exp_map;
        int exp_edges;
        int edges;
        bit fin;
        @(negedge clka);
        start[w] = 1'b1;
        model_place(ref_lfsr, nm_of(w), exp_map, exp_edges);
        @(posedge clka);
        #1;
        start[w] = 1'b0;
        check("busy_rise", busy[w], 1'b1);
        check("done_low_in_gen", place_done[w], 1'b0);
        fin = 1'b0;
        edges = -1;
        for (int k = 1; k <= 255 * nm_of(w) + 1 && !fin; k++) begin
            start[w] = (dbl && k == 2);
            @(posedge clka);
            #1;
            fin = place_done[w];
            if (fin) edges = k;
        end
        start[w] = 1'b0;
        check("done_within_bound", fin, 1'b1);
        check("latency", edges, exp_edges);
        check("map", mine_map[w], exp_map);
        check("count", mine_count[w], nm_of(w));
        check("busy_fall", busy[w], 1'b0);
        got_map = mine_map[w];
    endtask

    initial begin
        logic [24:0] m;
        logic [24:0] m_before;
        bit seen12;

        // Reset held for two cycles
        @(posedge clka);
        @(posedge clka);
        #1;
        for (int w = 0; w < 3; w++) begin
            check("rst_done", place_done[w], 1'b0);
            check("rst_busy", busy[w], 1'b0);
            check("rst_map", mine_map[w], 25'd0);
            check("rst_count", mine_count[w], 5'd0);
            check("rst_cell", cell_mine[w], 1'b0);
        end
        check("rst_lfsr", dut5.u_lfsr.lfsr, SEED);
        @(negedge clka);
        restart = 1'b0;

        // Basic placement one cycle after reset release, then read-port sweep
        run_game(0, 1'b0, m);
        check("popcount5", $countones(m), 5);
        for (int a = 0; a < 32; a++) begin
            @(negedge clka);
            cell_addr = 5'(a);
            @(posedge clka);
            #1;
            check("cell_mine", cell_mine[0], (a < 25) ? m[a] : 1'b0);
        end
        check("map_stable", mine_map[0], m);
        check("done_held", place_done[0], 1'b1);

        // start pulsed again during GEN is ignored
        run_game(0, 1'b1, m);

        // restart in the middle of placement
        @(negedge clka);
        start[0] = 1'b1;
        @(posedge clka);
        #1;
        start[0] = 1'b0;
        @(posedge clka);
        @(posedge clka);
        #1;
        m_before = mine_map[0];
        check("busy_mid_gen", busy[0], 1'b1);
        restart = 1'b1;
        @(posedge clka);
        #1;
        restart = 1'b0;
        check("abort_map", mine_map[0], 25'd0);
        check("abort_count", mine_count[0], 5'd0);
        check("abort_done", place_done[0], 1'b0);
        check("abort_busy", busy[0], 1'b0);
        check("abort_lfsr", dut5.u_lfsr.lfsr, SEED);
        @(posedge clka);
        #1;
        check("abort_stays_idle", busy[0], 1'b0);
        check("abort_map_held", mine_map[0] | (m_before & 25'd0), 25'd0);

        // restart and start together: restart wins, start dropped
        @(negedge clka);
        restart = 1'b1;
        start[0] = 1'b1;
        @(posedge clka);
        #1;
        restart = 1'b0;
        start[0] = 1'b0;
        @(posedge clka);
        #1;
        check("rst_start_busy", busy[0], 1'b0);
        check("rst_start_done", place_done[0], 1'b0);

        // Many games with random start spacing
        seen12 = 1'b0;
        for (int g = 0; g < 200; g++) begin
            repeat ($urandom_range(0, 12)) @(negedge clka);
            run_game(0, 1'b0, m);
            check("game_popcount", $countones(m), 5);
`ifdef MINE_SAFE_FIRST_EN
            check("safe_cell_clear", m[12], 1'b0);
`endif
            seen12 = seen12 | m[12];
        end
`ifndef MINE_SAFE_FIRST_EN
        check("cell12_eligible", seen12, 1'b1);
`endif

        // Boundary: 24 mines
        run_game(1, 1'b0, m);
        check("popcount24", $countones(m), 24);
`ifdef MINE_SAFE_FIRST_EN
        check("all_but_safe", m, 25'h1FF_FFFF & ~(25'd1 << 12));
`endif

        // Boundary: single mine
        run_game(2, 1'b0, m);
        check("popcount1", $countones(m), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
